cms_trace_gate: RTL
===================

# cms_trace_gate

Parametrised trace qualification and buffering stage for the continuous monitoring system. It sits between the processor's pc/instr probe and the AXI-stream packer. It detects newly executed instructions and qualifies them against NUM_RANGES include/exclude address windows, a start/end trigger pair with one-shot mode and a WFI stop counter. Qualified records are buffered in a FIFO_DEPTH-entry queue with a valid/ready output and a saturating drop counter.

## Interface
- XLEN, 64, pc and address width
- INSTR_WIDTH, 32, instruction width
- NUM_RANGES, 4, monitored address windows (1..60)
- TS_WIDTH, 32, timestamp and delta width
- FIFO_DEPTH, 4, output queue entries (power of two, >=2)
- WFI_STOP_THRESHOLD, 255, consecutive WFI cycles before capture stops (>=2)
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- pc  in  XLEN  probed program counter
- instr  in  INSTR_WIDTH  probed instruction
- en  in  1  capture enable
- ctrl_addr  in  8  control register address
- ctrl_wdata  in  XLEN  control write data
- ctrl_we  in  1  level write strobe; writes on every cycle it is high
- out_valid  out  1  queue head valid
- out_ready  in  1  consumer accepts the head on the same edge as out_valid
- out_pc, out_instr  out  XLEN / INSTR_WIDTH  head record
- out_delta  out  TS_WIDTH  cycles since the previous qualified event
- out_last  out  1  head instr is WFI (0x10500073)
- trace_active  out  1  trigger window open
- dropped_count  out  32  qualified events lost to a full queue; saturates at 0xFFFFFFFF

## Operation
- Probe pipeline: pc/instr register into d0, then d1 each cycle.
- The new-instruction event for d1 is true when either condition holds, and is also gated:
  - d0.pc != d1.pc, or wfi_cnt == WFI_STOP_THRESHOLD-1 (one repeat capture of a stalled WFI);
  - and d1.pc != 0.
- The qualify term for d1 requires all of:
  - event and en;
  - wfi_cnt < WFI_STOP_THRESHOLD;
  - trigger window open, or start trigger disabled;
  - end not reached, or end trigger disabled;
  - range filter passes.
- Range filter:
  - If any enabled range has mode=0 (include), d1.pc must lie in at least one of them, with lo <= pc <= hi inclusive.
  - d1.pc must not lie in any enabled range with mode=1 (exclude).
  - With no ranges enabled, the filter passes.
- Triggers are evaluated each cycle on the raw pc input:
  - A start match sets start_reached and clears end_reached.
  - An end match sets end_reached and clears start_reached.
  - If both match in the same cycle, end wins.
  - In one_shot=1, a start match is ignored once end_reached is set, until a REARM write.
  - trace_active = start_reached | ~start_en.
- WFI counter:
  - Increments when d1.instr == WFI, en=1 and wfi_cnt < threshold.
  - Clears to 0 when d1.instr != WFI.
- Timestamp: ts increments each cycle and wraps.
  - On each qualified event, delta = ts - last_ts (modulo 2^TS_WIDTH) and last_ts <= ts.
  - This update happens even if the event is dropped.
- Queue:
  - A qualified event pushes {d1.pc, d1.instr, delta}.
  - If the queue is full and no pop happens this cycle, the record is dropped and dropped_count increments.
  - Push and pop in the same cycle when full succeeds.
- Control map:
  - 0x00 START_EN, 0x01 END_EN, 0x02 START_ADDR, 0x03 END_ADDR.
  - 0x04 ONE_SHOT; 0x05 REARM (any data clears both reached flags).
  - 0x06 WFI_CNT (load); 0x07 CLEAR_DROPPED; 0x08 TS (load).
  - Range i registers: 0x10+4i EN, +1 MODE, +2 LO, +3 HI.
  - Flag registers take wdata[0]. Unmapped addresses are ignored.
  - A control write to a flag register has priority over a trigger update of the same flag in that cycle.

## Timing
- Reset (async, rst_n=0):
  - Outputs: out_valid=0, out_pc/out_instr/out_delta/out_last=0, trace_active=1, dropped_count=0.
  - Internal: queue empty, d0/d1=0, ts=last_ts=0, wfi_cnt=0.
  - Control: all enables and modes 0, range LO=0 and HI=all-ones, START_ADDR=0, END_ADDR=all-ones.
- Latency: pc/instr sampled at edge k is pushed at edge k+2. out_valid rises after edge k+2 if the queue was empty. No bypass path exists.
- Head registers hold stable while out_valid=1 and out_ready=0.
- A control write at edge k affects qualification from edge k+1.
- Reset asserted mid-operation discards the queue contents immediately.

## Test plan
- Probe pc 0x100, 0x104, 0x108, 0x108, 0x10C with out_ready=1 -> 4 records; delta of the 2nd, 3rd and 4th = 1, 1, 2.
- Configure range0 include [0x200,0x2FF] and range1 exclude [0x240,0x24F]; sweep pc 0x1F0..0x300 step 0x10 -> only 0x200-0x230 and 0x250-0x2F0 are output.
- Set START=0x400 and END=0x500 with one_shot=1; run through pc 0x400, 0x450, 0x500, 0x400, 0x450 -> 0x400 and 0x450 are captured once, then nothing; after REARM, capture resumes at the next 0x400.
- Hold out_ready=0 and push 6 events with FIFO_DEPTH=4 -> 4 records retained, dropped_count=2; CLEAR_DROPPED -> 0.
- Hold WFI at pc 0x600 for 300 cycles -> exactly 2 records at 0x600, both with out_last=1; the second appears when wfi_cnt reaches 254.
- Assert rst_n low while the queue holds 3 entries -> out_valid=0 asynchronously, dropped_count=0, and range settings return to defaults.

Source files
------------

// File: rtl/cms_trace_gate.sv
// cms_trace_gate: trace qualification and buffering between the pc/instr probe
// and the AXI-stream packer.
//   clk, rst_n            clock, asynchronous active-low reset
//   pc, instr, en         probe inputs and capture enable
//   ctrl_addr/wdata/we    control register write port (level strobe)
//   out_valid/out_ready   queue head handshake
//   out_pc/instr/delta    head record; out_last flags a WFI head
//   trace_active          trigger window open
//   dropped_count         saturating count of records lost to a full queue
module cms_trace_gate #(
  parameter int unsigned XLEN               = 64,
  parameter int unsigned INSTR_WIDTH        = 32,
  parameter int unsigned NUM_RANGES         = 4,
  parameter int unsigned TS_WIDTH           = 32,
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter int unsigned WFI_STOP_THRESHOLD = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [XLEN-1:0]        pc,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   en,
  input  logic [7:0]             ctrl_addr,
  input  logic [XLEN-1:0]        ctrl_wdata,
  input  logic                   ctrl_we,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [TS_WIDTH-1:0]    out_delta,
  output logic                   out_last,
  output logic                   trace_active,
  output logic [31:0]            dropped_count
);

  localparam int unsigned WC_W = $clog2(WFI_STOP_THRESHOLD + 1);
  localparam logic [INSTR_WIDTH-1:0] WFI_INSTR = INSTR_WIDTH'(32'h1050_0073);
  localparam logic [WC_W-1:0] WC_STOP   = WC_W'(WFI_STOP_THRESHOLD);
  localparam logic [WC_W-1:0] WC_REPEAT = WC_W'(WFI_STOP_THRESHOLD - 1);

  localparam logic [7:0] A_START_EN   = 8'h00;
  localparam logic [7:0] A_END_EN     = 8'h01;
  localparam logic [7:0] A_START_ADDR = 8'h02;
  localparam logic [7:0] A_END_ADDR   = 8'h03;
  localparam logic [7:0] A_ONE_SHOT   = 8'h04;
  localparam logic [7:0] A_REARM      = 8'h05;
  localparam logic [7:0] A_WFI_CNT    = 8'h06;
  localparam logic [7:0] A_CLR_DROP   = 8'h07;
  localparam logic [7:0] A_TS         = 8'h08;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic [TS_WIDTH-1:0]    delta;
    logic                   last;
  } rec_t;

  logic [XLEN-1:0]        d0_pc_q, d0_pc_d, d1_pc_q, d1_pc_d;
  logic [INSTR_WIDTH-1:0] d0_instr_q, d0_instr_d, d1_instr_q, d1_instr_d;
  logic                   d1_new_q, d1_new_d;
  logic [TS_WIDTH-1:0]    ts_q, ts_d, last_ts_q, last_ts_d;
  logic [WC_W-1:0]        wfi_cnt_q, wfi_cnt_d;
  logic                   start_en_q, start_en_d, end_en_q, end_en_d;
  logic                   one_shot_q, one_shot_d;
  logic [XLEN-1:0]        start_addr_q, start_addr_d, end_addr_q, end_addr_d;
  logic                   start_rch_q, start_rch_d, end_rch_q, end_rch_d;
  logic                   trace_active_q, trace_active_d;
  logic [NUM_RANGES-1:0]  rng_en_q, rng_en_d, rng_mode_q, rng_mode_d;
  logic [XLEN-1:0]        rng_lo_q [NUM_RANGES];
  logic [XLEN-1:0]        rng_lo_d [NUM_RANGES];
  logic [XLEN-1:0]        rng_hi_q [NUM_RANGES];
  logic [XLEN-1:0]        rng_hi_d [NUM_RANGES];
  rec_t                   q_q [FIFO_DEPTH];
  rec_t                   q_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  vld_q, vld_d;
  logic [31:0]            drop_cnt_q, drop_cnt_d;

  logic any_incl, in_incl, in_excl, range_ok, evt, qualify;
  logic pop, full, push, drop, placed, st_match, end_match;
  rec_t rec;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_pc_q        <= '0;
      d0_instr_q     <= '0;
      d1_pc_q        <= '0;
      d1_instr_q     <= '0;
      d1_new_q       <= 1'b0;
      ts_q           <= '0;
      last_ts_q      <= '0;
      wfi_cnt_q      <= '0;
      start_en_q     <= 1'b0;
      end_en_q       <= 1'b0;
      one_shot_q     <= 1'b0;
      start_addr_q   <= '0;
      end_addr_q     <= '1;
      start_rch_q    <= 1'b0;
      end_rch_q      <= 1'b0;
      trace_active_q <= 1'b1;
      rng_en_q       <= '0;
      rng_mode_q     <= '0;
      for (int i = 0; i < NUM_RANGES; i++) begin
        rng_lo_q[i] <= '0;
        rng_hi_q[i] <= '1;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) q_q[i] <= '0;
      vld_q          <= '0;
      drop_cnt_q     <= '0;
    end else begin
      d0_pc_q        <= d0_pc_d;
      d0_instr_q     <= d0_instr_d;
      d1_pc_q        <= d1_pc_d;
      d1_instr_q     <= d1_instr_d;
      d1_new_q       <= d1_new_d;
      ts_q           <= ts_d;
      last_ts_q      <= last_ts_d;
      wfi_cnt_q      <= wfi_cnt_d;
      start_en_q     <= start_en_d;
      end_en_q       <= end_en_d;
      one_shot_q     <= one_shot_d;
      start_addr_q   <= start_addr_d;
      end_addr_q     <= end_addr_d;
      start_rch_q    <= start_rch_d;
      end_rch_q      <= end_rch_d;
      trace_active_q <= trace_active_d;
      rng_en_q       <= rng_en_d;
      rng_mode_q     <= rng_mode_d;
      rng_lo_q       <= rng_lo_d;
      rng_hi_q       <= rng_hi_d;
      q_q            <= q_d;
      vld_q          <= vld_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  // Qualification, triggers, control writes and queue update
  always_comb begin
    d0_pc_d      = pc;
    d0_instr_d   = instr;
    d1_pc_d      = d0_pc_q;
    d1_instr_d   = d0_instr_q;
    // d0/d1 mismatch travels with the record so d1 knows it is a fresh pc
    d1_new_d     = (d0_pc_q != d1_pc_q);
    ts_d         = ts_q + TS_WIDTH'(1);
    last_ts_d    = last_ts_q;
    wfi_cnt_d    = wfi_cnt_q;
    start_en_d   = start_en_q;
    end_en_d     = end_en_q;
    one_shot_d   = one_shot_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    start_rch_d  = start_rch_q;
    end_rch_d    = end_rch_q;
    rng_en_d     = rng_en_q;
    rng_mode_d   = rng_mode_q;
    rng_lo_d     = rng_lo_q;
    rng_hi_d     = rng_hi_q;
    q_d          = q_q;
    vld_d        = vld_q;
    drop_cnt_d   = drop_cnt_q;
    any_incl     = 1'b0;
    in_incl      = 1'b0;
    in_excl      = 1'b0;
    placed       = 1'b0;

    // Address window filter on d1
    for (int i = 0; i < NUM_RANGES; i++) begin
      if (rng_en_q[i]) begin
        if (!rng_mode_q[i]) begin
          any_incl = 1'b1;
          if (d1_pc_q >= rng_lo_q[i] && d1_pc_q <= rng_hi_q[i]) in_incl = 1'b1;
        end else if (d1_pc_q >= rng_lo_q[i] && d1_pc_q <= rng_hi_q[i]) begin
          in_excl = 1'b1;
        end
      end
    end
    range_ok = (!any_incl || in_incl) && !in_excl;

    // A stalled WFI gets one repeat capture just before the stop threshold
    evt     = (d1_new_q || wfi_cnt_q == WC_REPEAT) && (d1_pc_q != '0);
    qualify = evt && en && (wfi_cnt_q < WC_STOP)
              && (start_rch_q || !start_en_q) && (!end_rch_q || !end_en_q) && range_ok;

    if (d1_instr_q != WFI_INSTR) wfi_cnt_d = '0;
    else if (en && wfi_cnt_q < WC_STOP) wfi_cnt_d = wfi_cnt_q + WC_W'(1);

    if (qualify) last_ts_d = ts_q;
    rec.pc    = d1_pc_q;
    rec.instr = d1_instr_q;
    rec.delta = ts_q - last_ts_q;
    rec.last  = (d1_instr_q == WFI_INSTR);

    // Triggers on the raw probe pc; end wins a simultaneous match
    st_match  = start_en_q && (pc == start_addr_q) && !(one_shot_q && end_rch_q);
    end_match = end_en_q && (pc == end_addr_q);
    if (st_match) begin
      start_rch_d = 1'b1;
      end_rch_d   = 1'b0;
    end
    if (end_match) begin
      end_rch_d   = 1'b1;
      start_rch_d = 1'b0;
    end

    // Queue kept head-aligned so the outputs come straight from entry 0
    pop  = vld_q[0] && out_ready;
    full = vld_q[FIFO_DEPTH-1];
    push = qualify && (!full || pop);
    drop = qualify && full && !pop;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        q_d[i]   = q_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      vld_d[FIFO_DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (!placed && !vld_d[i]) begin
          q_d[i]   = rec;
          vld_d[i] = 1'b1;
          placed   = 1'b1;
        end
      end
    end
    if (drop && drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_q + 32'd1;

    // Control writes override same-cycle trigger and counter updates
    if (ctrl_we) begin
      case (ctrl_addr)
        A_START_EN:   start_en_d   = ctrl_wdata[0];
        A_END_EN:     end_en_d     = ctrl_wdata[0];
        A_START_ADDR: start_addr_d = ctrl_wdata;
        A_END_ADDR:   end_addr_d   = ctrl_wdata;
        A_ONE_SHOT:   one_shot_d   = ctrl_wdata[0];
        A_REARM: begin
          start_rch_d = 1'b0;
          end_rch_d   = 1'b0;
        end
        A_WFI_CNT:    wfi_cnt_d    = WC_W'(ctrl_wdata);
        A_CLR_DROP:   drop_cnt_d   = '0;
        A_TS:         ts_d         = TS_WIDTH'(ctrl_wdata);
        default: ;
      endcase
      for (int i = 0; i < NUM_RANGES; i++) begin
        if (ctrl_addr == 8'(16 + 4 * i))     rng_en_d[i]   = ctrl_wdata[0];
        if (ctrl_addr == 8'(16 + 4 * i + 1)) rng_mode_d[i] = ctrl_wdata[0];
        if (ctrl_addr == 8'(16 + 4 * i + 2)) rng_lo_d[i]   = ctrl_wdata;
        if (ctrl_addr == 8'(16 + 4 * i + 3)) rng_hi_d[i]   = ctrl_wdata;
      end
    end

    trace_active_d = start_rch_d || !start_en_d;
  end

  assign out_valid     = vld_q[0];
  assign out_pc        = q_q[0].pc;
  assign out_instr     = q_q[0].instr;
  assign out_delta     = q_q[0].delta;
  assign out_last      = q_q[0].last;
  assign trace_active  = trace_active_q;
  assign dropped_count = drop_cnt_q;

endmodule
